// File: rtl/bram_pkg.sv
// Shared constants and FSM states for the burst reader
// and the memory it fronts.
package bram_pkg;
  localparam int DEPTH = 10;
  localparam int AW = 4;
  localparam int DW = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPT,
    PRES
  } state_t;
endpackage

// File: rtl/bram_addr_step.sv
// Modulo-DEPTH address increment.
// Wraps to zero after the last valid location.
module bram_addr_step #(
  parameter int DEPTH = 10,
  parameter int AW = 4
) (
  input  logic [AW-1:0] addr,
  output logic [AW-1:0] next_addr
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  assign next_addr = (addr == LAST) ? '0 : addr + AW'(1);
endmodule

// File: rtl/bram_reader.sv
// Burst reader: walks a synchronous memory one word
// at a time and hands each word downstream.
module bram_reader #(
  parameter int DEPTH = bram_pkg::DEPTH,
  parameter int AW = bram_pkg::AW,
  parameter int DW = bram_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] length,
  output logic [AW-1:0] addr,
  input  logic [DW-1:0] mem_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [7:0]    sum
);
  import bram_pkg::*;

  localparam logic [AW:0] LIMIT = (AW + 1)'(DEPTH);

  state_t        state;
  state_t        state_n;
  logic [AW-1:0] remaining;
  logic [AW-1:0] remaining_n;
  logic [AW-1:0] addr_n;
  logic [AW-1:0] addr_step;
  logic [DW-1:0] out_data_n;
  logic          out_valid_n;
  logic          busy_n;
  logic          done_n;
  logic          err_n;
  logic [7:0]    sum_n;
  logic          legal;
  logic          hs;

  bram_addr_step #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_step (
    .addr     (addr),
    .next_addr(addr_step)
  );

  assign legal = (length != '0)
              && ({1'b0, length} <= LIMIT)
              && ({1'b0, start_addr} < LIMIT);

  assign hs = out_valid && out_ready;

  always_comb begin
    state_n     = state;
    addr_n      = addr;
    remaining_n = remaining;
    out_data_n  = out_data;
    out_valid_n = out_valid;
    busy_n      = busy;
    done_n      = 1'b0;
    err_n       = 1'b0;
    sum_n       = sum;
    unique case (state)
      IDLE: begin
        // done is high in the first IDLE cycle; start is
        // not honoured until it has dropped
        if (start && !done) begin
          if (legal) begin
            addr_n      = start_addr;
            remaining_n = length;
            sum_n       = '0;
            busy_n      = 1'b1;
            state_n     = WAIT;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      WAIT: begin
        state_n = CAPT;
      end
      CAPT: begin
        out_data_n  = mem_data;
        out_valid_n = 1'b1;
        state_n     = PRES;
      end
      PRES: begin
        if (hs) begin
          out_valid_n = 1'b0;
          sum_n       = sum + 8'(out_data);
          if (remaining > AW'(1)) begin
            addr_n      = addr_step;
            remaining_n = remaining - AW'(1);
            state_n     = WAIT;
          end else begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      sum       <= '0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      remaining <= remaining_n;
      out_data  <= out_data_n;
      out_valid <= out_valid_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
      sum       <= sum_n;
    end
  end
endmodule

// File: tb/tb_bram_reader.sv
// Self-checking bench for bram_reader with a
// synchronous ROM model and expected-word queue.
module tb_bram_reader;
  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] start_addr;
  logic [3:0] length;
  logic [3:0] addr;
  logic [3:0] mem_data;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] sum;

  logic [3:0] rom [16];
  int compared;
  int mismatched;

  bram_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_addr(start_addr),
    .length    (length),
    .addr      (addr),
    .mem_data  (mem_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .sum       (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= rom[addr];

  task automatic do_burst(
    input logic [3:0] sa,
    input logic [3:0] len,
    input int         stall_idx,
    input int         stall_cyc,
    input bit         chk_lat,
    input bit         poke,
    input int         abort_idx
  );
    logic [3:0] a;
    logic [7:0] esum;
    logic [3:0] ew;
    logic [3:0] ea;
    logic [3:0] wq[$];
    logic [3:0] aq[$];
    int word;
    int stalls;
    int cyc;
    int done_cnt;
    int budget;
    a = sa;
    esum = 8'd0;
    for (int i = 0; i < int'(len); i++) begin
      wq.push_back(rom[a]);
      aq.push_back(a);
      esum = esum + 8'(rom[a]);
      a = (a == 4'd9) ? 4'd0 : a + 4'd1;
    end
    word = 0;
    stalls = 0;
    done_cnt = 0;
    budget = int'(len) * 3 + stall_cyc + 10;
    out_ready = 1'b1;
    start_addr = sa;
    length = len;
    start = 1'b1;
    @(negedge clk);
    cyc = 1;
    if (poke) begin
      start_addr = 4'd3;
      length = 4'd1;
    end else begin
      start = 1'b0;
    end
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL busy_on: got %b want 1", busy);
    end
    while (word < int'(len) && cyc < budget) begin
      if (done) done_cnt++;
      if (out_valid) begin
        if (word == 0 && stalls == 0 && chk_lat) begin
          compared++;
          if (cyc != 3) begin
            mismatched++;
            $display("FAIL latency: got %0d edges want 3", cyc);
          end
        end
        if (word == abort_idx) begin
          rst = 1'b1;
          start = 1'b0;
          @(negedge clk);
          rst = 1'b0;
          compared++;
          if ({addr, out_data, out_valid, busy, done, err, sum}
              !== 19'd0) begin
            mismatched++;
            $display("FAIL abort_reset: addr %0h data %0h v %b b %b d %b e %b sum %0d want all 0",
                     addr, out_data, out_valid, busy, done, err, sum);
          end
          repeat (4) begin
            @(negedge clk);
            if (done) done_cnt++;
          end
          compared++;
          if (done_cnt != 0) begin
            mismatched++;
            $display("FAIL abort_done: got %0d pulses want 0", done_cnt);
          end
          return;
        end
        if (word == stall_idx && stalls < stall_cyc) begin
          out_ready = 1'b0;
          compared++;
          if (out_data !== wq[0] || addr !== aq[0] || out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL stall_hold: data %0h addr %0h v %b want data %0h addr %0h v 1",
                     out_data, addr, out_valid, wq[0], aq[0]);
          end
          stalls++;
        end else begin
          out_ready = 1'b1;
          ew = wq.pop_front();
          ea = aq.pop_front();
          compared++;
          if (out_data !== ew || addr !== ea) begin
            mismatched++;
            $display("FAIL word%0d: data %0h addr %0h want data %0h addr %0h",
                     word, out_data, addr, ew, ea);
          end
          word++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (word < int'(len)) begin
      mismatched++;
      $display("FAIL timeout: got %0d words want %0d", word, len);
      start = 1'b0;
      return;
    end
    compared++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || sum !== esum) begin
      mismatched++;
      $display("FAIL burst_end: done %b busy %b v %b sum %0d want 1 0 0 %0d",
               done, busy, out_valid, sum, esum);
    end
    compared++;
    if (done_cnt != 0) begin
      mismatched++;
      $display("FAIL early_done: got %0d want 0", done_cnt);
    end
    @(negedge clk);
    start = 1'b0;
    compared++;
    if (done !== 1'b0 || busy !== 1'b0 || sum !== esum) begin
      mismatched++;
      $display("FAIL after_done: done %b busy %b sum %0d want 0 0 %0d",
               done, busy, sum, esum);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    start_addr = 4'd0;
    length = 4'd0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    compared++;
    if ({addr, out_data, out_valid, busy, done, err, sum} !== 19'd0) begin
      mismatched++;
      $display("FAIL reset: addr %0h data %0h v %b b %b d %b e %b sum %0d want all 0",
               addr, out_data, out_valid, busy, done, err, sum);
    end
  endtask

  task automatic test_basic();
    do_burst(4'd0, 4'd3, -1, 0, 1'b1, 1'b0, -1);
  endtask

  task automatic test_illegal();
    logic [3:0] sas [3];
    logic [3:0] lens [3];
    sas = '{4'd0, 4'd10, 4'd0};
    lens = '{4'd0, 4'd1, 4'd11};
    for (int i = 0; i < 3; i++) begin
      start_addr = sas[i];
      length = lens[i];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      compared++;
      if (err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0
          || sum !== 8'd28 || addr !== 4'd2) begin
        mismatched++;
        $display("FAIL illegal%0d: err %b busy %b v %b sum %0d addr %0h want 1 0 0 28 2",
                 i, err, busy, out_valid, sum, addr);
      end
      @(negedge clk);
      compared++;
      if (err !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL illegal%0d_after: err %b busy %b v %b want 0 0 0",
                 i, err, busy, out_valid);
      end
    end
  endtask

  task automatic test_wrap();
    do_burst(4'd8, 4'd4, -1, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_full();
    do_burst(4'd0, 4'd10, -1, 0, 1'b1, 1'b0, -1);
  endtask

  task automatic test_stall();
    do_burst(4'd0, 4'd3, 1, 5, 1'b0, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    do_burst(4'd2, 4'd2, -1, 0, 1'b1, 1'b1, -1);
    repeat (3) @(negedge clk);
    compared++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || sum !== 8'd15) begin
      mismatched++;
      $display("FAIL idle_hold: busy %b v %b sum %0d want 0 0 15",
               busy, out_valid, sum);
    end
  endtask

  task automatic test_reset_mid();
    do_burst(4'd0, 4'd3, -1, 0, 1'b0, 1'b0, 1);
    do_burst(4'd5, 4'd2, -1, 0, 1'b1, 1'b0, -1);
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    rom = '{4'hA, 4'h6, 4'hC, 4'h3, 4'h9, 4'h5, 4'hF, 4'h0,
            4'hB, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    test_reset();
    test_basic();
    test_illegal();
    test_wrap();
    test_full();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule

// File: doc/bram_reader.md
BRAM_READER -- requirements
Module: bram_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 10, number of valid memory locations.
REQ-002 SHALL have parameter AW, default 4, address width.
REQ-003 SHALL have parameter DW, default 4, data width.
REQ-004 SHALL use one clock and a reset that is synchronous and active-high.
REQ-005 SHALL have port clk  input  1  rising-edge clock shared with the memory.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port start  input  1  request a burst read, sampled in IDLE only.
REQ-008 SHALL have port start_addr  input  AW  first address of the burst.
REQ-009 SHALL have port length  input  AW  words in the burst, legal range 1..DEPTH.
REQ-010 SHALL have port addr  output  AW  registered address to the memory.
REQ-011 SHALL have port mem_data  input  DW  memory read data, valid one clock after addr is sampled.
REQ-012 SHALL have port out_data  output  DW  word presented downstream.
REQ-013 SHALL have port out_valid  output  1  out_data is valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts the word.
REQ-015 SHALL have port busy  output  1  burst in progress.
REQ-016 SHALL have port done  output  1  one-cycle pulse after the final word is accepted.
REQ-017 SHALL have port err  output  1  one-cycle pulse on a rejected start.
REQ-018 SHALL have port sum  output  8  running sum of accepted words in the current or last burst.

Function
REQ-019 SHALL implement the states IDLE, WAIT, CAPT and PRES.
REQ-020 On a legal start in IDLE, SHALL load addr<=start_addr, remaining<=length, sum<=0, busy<=1 and go to WAIT.
REQ-021 A start SHALL be legal only when length is in 1..DEPTH and start_addr<=DEPTH-1; an illegal start SHALL pulse err for one cycle, stay in IDLE and change no other output.
REQ-022 WAIT SHALL last exactly one cycle, during which the memory samples addr, then go to CAPT.
REQ-023 In CAPT, SHALL register out_data<=mem_data, set out_valid<=1 and go to PRES.
REQ-024 SHALL assert out_valid on the third rising edge after the edge that accepts start.
REQ-025 In PRES, SHALL hold out_data, out_valid and addr stable until out_valid&&out_ready.
REQ-026 On a PRES handshake, SHALL clear out_valid and set sum<=sum+out_data (zero-extended, no overflow possible since 10*15=150).
REQ-027 On a PRES handshake with remaining>1, SHALL set addr<=next(addr), remaining<=remaining-1 and go to WAIT.
REQ-028 next(addr) SHALL be addr+1, or 0 when addr==DEPTH-1 (wrap-around).
REQ-029 On a PRES handshake with remaining==1, SHALL pulse done for one cycle, clear busy and go to IDLE.
REQ-030 start SHALL be ignored outside IDLE, including in the cycle in which done is high.
REQ-031 Minimum throughput SHALL be one word per 3 cycles with out_ready held high.
REQ-032 sum SHALL hold its value in IDLE until the next legal start.

Reset
REQ-033 While rst is high at a clock edge, SHALL set state=IDLE, addr=0, out_data=0, out_valid=0, busy=0, done=0, err=0, sum=0 and remaining=0.
REQ-034 A reset during a burst SHALL abandon the burst with no done pulse; the first legal start after reset SHALL behave as from power-up.

Structure
REQ-035 Package bram_pkg SHALL hold DEPTH, AW, DW and the state enumeration, shared with the memory block.
REQ-036 The modulo-DEPTH increment SHALL be a sub-module bram_addr_step (combinational, AW in, AW out).

Verification (memory contents 0..9 = A,6,C,3,9,5,F,0,B,7)
REQ-037 start_addr=0, length=3, out_ready=1 -> the bench SHALL observe out_data A,6,C, done once and sum=28.
REQ-038 start_addr=8, length=4 -> the bench SHALL observe out_data B,7,A,6 (wrap) and sum=34.
REQ-039 start_addr=0, length=10 -> the bench SHALL observe all ten words in order and sum=78; out_valid SHALL rise on the third edge after start.
REQ-040 length=3 with out_ready low for 5 cycles on the second word -> the bench SHALL observe out_data=6 held with out_valid high, and sum=28.
REQ-041 length=0, then start_addr=10 -> the bench SHALL observe one err pulse each, with busy and out_valid remaining 0.
REQ-042 rst asserted in PRES of the second word, then start_addr=5, length=2 -> the bench SHALL observe no done, all outputs reset, then out_data 5,F and sum=20.
